// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Front-end conditioning for the operand switches and the run/stop button.
//   Each of the three raw inputs is brought into the clk domain by a two-flop
//   synchroniser and then debounced. A debounced level only moves after the
//   synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive
//   cycles. The debounced levels drive rising-edge pulses, a change pulse and
//   a run/stop toggle. Every output comes straight from a flop.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive mismatch cycles before a level updates (>=1)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-high reset; clears all state
//   a_raw       in   raw operand-A switch (asynchronous)
//   b_raw       in   raw operand-B switch (asynchronous)
//   rs_btn_raw  in   raw run/stop pushbutton, high = pressed (asynchronous)
//   a           out  debounced level of a_raw
//   b           out  debounced level of b_raw
//   runstop     out  run/stop state, toggled by each debounced press (1 = run)
//   a_rise      out  one-cycle pulse when a goes 0->1
//   b_rise      out  one-cycle pulse when b goes 0->1
//   changed     out  one-cycle pulse when a or b changes in either direction
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  input  logic rs_btn_raw,
  output logic a,
  output logic b,
  output logic runstop,
  output logic a_rise,
  output logic b_rise,
  output logic changed
);

  // Channel slots: 0 = a, 1 = b, 2 = run/stop button.
  localparam int unsigned     N_CH     = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]            raw;
  logic [N_CH-1:0]            sync1_q, sync1_d;
  logic [N_CH-1:0]            sync2_q, sync2_d;
  logic [N_CH-1:0]            stable_q, stable_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]            rise;
  logic                       runstop_q, runstop_d;
  logic                       a_rise_q, a_rise_d;
  logic                       b_rise_q, b_rise_d;
  logic                       changed_q, changed_d;

  assign raw = {rs_btn_raw, b_raw, a_raw};

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      // Counter clears on agreement, so any bounce back restarts the count.
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Edge outputs look at the next debounced level so the pulse appears in
    // the same cycle the level itself changes.
    rise      = stable_d & ~stable_q;
    a_rise_d  = rise[0];
    b_rise_d  = rise[1];
    changed_d = (stable_d[0] ^ stable_q[0]) | (stable_d[1] ^ stable_q[1]);
    runstop_d = runstop_q ^ rise[2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      runstop_q <= 1'b0;
      a_rise_q  <= 1'b0;
      b_rise_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      runstop_q <= runstop_d;
      a_rise_q  <= a_rise_d;
      b_rise_q  <= b_rise_d;
      changed_q <= changed_d;
    end
  end

  assign a       = stable_q[0];
  assign b       = stable_q[1];
  assign runstop = runstop_q;
  assign a_rise  = a_rise_q;
  assign b_rise  = b_rise_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_raw = 1'b0, b_raw = 1'b0, rs_btn_raw = 1'b0;
  logic a, b, runstop, a_rise, b_rise, changed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];

  input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .a_raw(a_raw), .b_raw(b_raw), .rs_btn_raw(rs_btn_raw),
    .a(a), .b(b), .runstop(runstop),
    .a_rise(a_rise), .b_rise(b_rise), .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: a debounced level flips once the raw samples taken
  // 2..DEB+1 edges ago (the synchroniser delay) all disagree with it.
  initial begin : model
    bit hist[3][DEB+2];
    bit lvl[3];
    bit old_lvl[3];
    bit run;
    bit smp[3];
    bit all_diff;
    foreach (hist[c, j]) hist[c][j] = 1'b0;
    foreach (lvl[c]) lvl[c] = 1'b0;
    run = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        foreach (hist[c, j]) hist[c][j] = 1'b0;
        foreach (lvl[c]) lvl[c] = 1'b0;
        run = 1'b0;
        exp_q.push_back(6'b0);
      end else begin
        smp[0] = a_raw; smp[1] = b_raw; smp[2] = rs_btn_raw;
        for (int c = 0; c < 3; c++) begin
          old_lvl[c] = lvl[c];
          for (int j = DEB + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
          hist[c][0] = smp[c];
          all_diff = 1'b1;
          for (int j = 2; j <= DEB + 1; j++)
            if (hist[c][j] == lvl[c]) all_diff = 1'b0;
          if (all_diff) lvl[c] = ~lvl[c];
        end
        if (lvl[2] && !old_lvl[2]) run = ~run;
        exp_q.push_back({lvl[0], lvl[1], run,
                         lvl[0] & ~old_lvl[0], lvl[1] & ~old_lvl[1],
                         (lvl[0] ^ old_lvl[0]) | (lvl[1] ^ old_lvl[1])});
      end
    end
  end

  // Monitor: every cycle presents a fresh output bundle.
  initial begin : monitor
    logic [5:0] got, want;
    forever begin
      @(posedge clk);
      #2;
      got = {a, b, runstop, a_rise, b_rise, changed};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got=%b want=<none>", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL outputs t=%0t {a,b,runstop,a_rise,b_rise,changed} got=%b want=%b",
                   $time, got, want);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check(input string name);
    logic [5:0] got;
    #1 reset = 1'b1;
    #2;
    got = {a, b, runstop, a_rise, b_rise, changed};
    n_checks++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL %s got=%b want=000000", name, got);
    end
  endtask

  initial begin : stimulus
    int hold;
    // 1: reset held with raw inputs low
    cycles(5);
    reset = 1'b0;
    // 2: single rising switch
    a_raw = 1'b1;
    cycles(12);
    a_raw = 1'b0;
    cycles(12);
    // 3: short glitches
    a_raw = 1'b1; cycles(1); a_raw = 1'b0; cycles(10);
    a_raw = 1'b1; cycles(3); a_raw = 1'b0; cycles(10);
    // exact-threshold hold
    a_raw = 1'b1; cycles(DEB); a_raw = 1'b0; cycles(12);
    // 4: simultaneous rise, then simultaneous fall
    a_raw = 1'b1; b_raw = 1'b1; cycles(12);
    a_raw = 1'b0; b_raw = 1'b0; cycles(12);
    // 5: two button presses
    repeat (2) begin
      rs_btn_raw = 1'b1; cycles(6);
      rs_btn_raw = 1'b0; cycles(10);
    end
    // async reset between edges while a is high
    a_raw = 1'b1; cycles(12);
    async_reset_check("async_reset_clears");
    cycles(3);
    reset = 1'b0;
    a_raw = 1'b0;
    cycles(12);
    // 6: reset two cycles into a debounce of b
    b_raw = 1'b1;
    cycles(2);
    async_reset_check("reset_mid_debounce");
    cycles(3);
    reset = 1'b0;
    cycles(12);
    b_raw = 1'b0;
    cycles(12);
    // random phase with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 2) == 0) b_raw = ~b_raw;
      if ($urandom_range(0, 2) == 0) rs_btn_raw = ~rs_btn_raw;
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
      end
      hold = $urandom_range(1, 7);
      cycles(hold);
    end
    a_raw = 1'b0; b_raw = 1'b0; rs_btn_raw = 1'b0;
    cycles(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
